// File: rtl/prbs10_checker.sv
// Self-synchronising checker for the 10-bit XNOR PRBS (~(Q[9]^Q[6]) into Q[0]).
// Optional saturating bit counter built only when PRBS10_CHECKER_BITCNT_EN is defined.
module prbs10_checker #(
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_CNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             r,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int MW = $clog2(LOCK_CNT) + 1;
  localparam int UW = $clog2(UNLOCK_CNT) + 1;
  localparam logic [MW-1:0] LOCK_V   = MW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLOCK_V = UW'(UNLOCK_CNT);
  localparam logic [3:0]    FILL_V   = 4'd10;

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e           state_q;
  logic [9:0]       s_q;
  logic [3:0]       fill_q;
  logic [MW-1:0]    match_q;
  logic [UW-1:0]    miss_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_cnt_q;

  logic          exp_bit;
  logic          hit;
  logic [MW-1:0] match_d;
  logic [UW-1:0] miss_d;

  assign exp_bit = ~(s_q[9] ^ s_q[6]);
  assign hit     = (bit_in == exp_bit);
  assign match_d = match_q + 1'b1;
  assign miss_d  = miss_q + 1'b1;

  // NOTE: every register below is written with <= so all of them update from
  // the same pre-edge values; blocking writes here would chain within one edge.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q     <= HUNT;
      s_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bit_valid) begin
        unique case (state_q)
          HUNT: begin
            s_q <= {s_q[8:0], bit_in};
            if (fill_q != FILL_V) begin
              fill_q <= fill_q + 4'd1;
            end else if (hit && (s_q != 10'h3FF)) begin
              // All-ones history self-predicts under XNOR, so it never counts.
              if (match_d == LOCK_V) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                match_q  <= '0;
                miss_q   <= '0;
              end else begin
                match_q <= match_d;
              end
            end else begin
              match_q <= '0;
            end
          end
          LOCKED: begin
            // Free-run on the prediction so line errors cannot corrupt it.
            s_q <= {s_q[8:0], exp_bit};
            if (hit) begin
              miss_q <= '0;
            end else begin
              err_pulse_q <= 1'b1;
              if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
              if (miss_d == UNLOCK_V) begin
                state_q  <= HUNT;
                locked_q <= 1'b0;
                fill_q   <= '0;
                miss_q   <= '0;
              end else begin
                miss_q <= miss_d;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

`ifdef PRBS10_CHECKER_BITCNT_EN
  logic [CNT_W-1:0] bit_cnt_q;

  always_ff @(posedge clk) begin
    if (r) begin
      bit_cnt_q <= '0;
    end else if (bit_valid && (state_q == LOCKED) && (bit_cnt_q != '1)) begin
      bit_cnt_q <= bit_cnt_q + 1'b1;
    end
  end

  assign bit_count = bit_cnt_q;
`else
  assign bit_count = '0;
`endif

endmodule
